// File: rtl/execute_stage_slice.sv
// Execute-stage slice: D/E register, operand forwarding, ALU and E/M register.
// Optional build macro ALU_FLAGS_EN adds registered {Z,N,C,V} flags on flags_memory.
module execute_stage_slice #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_de,
    input  logic [CTRL_W-1:0] ctrl_decode,
    input  logic [DATA_W-1:0] srcA_in,
    input  logic [DATA_W-1:0] srcB_in,
    input  logic [REG_AW-1:0] rs1_decode,
    input  logic [REG_AW-1:0] rs2_decode,
    input  logic [REG_AW-1:0] rd_decode,
    input  logic [1:0]        select_forward_mux_A,
    input  logic [1:0]        select_forward_mux_B,
    input  logic [DATA_W-1:0] writeback_data,
    output logic [REG_AW-1:0] rs1_execute,
    output logic [REG_AW-1:0] rs2_execute,
    output logic [REG_AW-1:0] rd_execute,
    output logic              write_memory_enable_execute,
    output logic              wre_memory,
    output logic              write_memory_enable_memory,
    output logic [1:0]        select_writeback_data_mux_memory,
    output logic [DATA_W-1:0] alu_result_memory,
    output logic [DATA_W-1:0] srcA_memory,
    output logic [DATA_W-1:0] srcB_memory,
`ifdef ALU_FLAGS_EN
    output logic [3:0]        flags_memory,
`endif
    output logic [REG_AW-1:0] rd_memory
);

    logic              r_de_wre;
    logic              r_de_wme;
    logic [1:0]        r_de_wbsel;
    logic [3:0]        r_de_aluop;
    logic [DATA_W-1:0] r_de_srca;
    logic [DATA_W-1:0] r_de_srcb;
    logic [REG_AW-1:0] r_de_rs1;
    logic [REG_AW-1:0] r_de_rs2;
    logic [REG_AW-1:0] r_de_rd;

    logic              r_em_wre;
    logic              r_em_wme;
    logic [1:0]        r_em_wbsel;
    logic [DATA_W-1:0] r_em_alu;
    logic [DATA_W-1:0] r_em_srca;
    logic [DATA_W-1:0] r_em_srcb;
    logic [REG_AW-1:0] r_em_rd;

    logic [DATA_W-1:0] w_opa;
    logic [DATA_W-1:0] w_opb;
    logic [DATA_W-1:0] w_alu;
    logic [CTRL_W-9:0] w_unused_ctrl;

    // Upper control bits are reserved and deliberately dropped.
    assign w_unused_ctrl = ctrl_decode[CTRL_W-1:8];

    // A flushed bubble is all zeros: no writes, aluOp ADD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_de_wre   <= 1'b0;
            r_de_wme   <= 1'b0;
            r_de_wbsel <= '0;
            r_de_aluop <= '0;
            r_de_srca  <= '0;
            r_de_srcb  <= '0;
            r_de_rs1   <= '0;
            r_de_rs2   <= '0;
            r_de_rd    <= '0;
        end else if (flush_de) begin
            r_de_wre   <= 1'b0;
            r_de_wme   <= 1'b0;
            r_de_wbsel <= '0;
            r_de_aluop <= '0;
            r_de_srca  <= '0;
            r_de_srcb  <= '0;
            r_de_rs1   <= '0;
            r_de_rs2   <= '0;
            r_de_rd    <= '0;
        end else begin
            r_de_wre   <= ctrl_decode[0];
            r_de_wme   <= ctrl_decode[1];
            r_de_wbsel <= ctrl_decode[3:2];
            r_de_aluop <= ctrl_decode[7:4];
            r_de_srca  <= srcA_in;
            r_de_srcb  <= srcB_in;
            r_de_rs1   <= rs1_decode;
            r_de_rs2   <= rs2_decode;
            r_de_rd    <= rd_decode;
        end
    end

    // Forwarding from E/M uses the value registered before this edge.
    always_comb begin
        w_opa = r_de_srca;
        case (select_forward_mux_A)
            2'd1:    w_opa = writeback_data;
            2'd2:    w_opa = r_em_alu;
            default: w_opa = r_de_srca;
        endcase
        w_opb = r_de_srcb;
        case (select_forward_mux_B)
            2'd1:    w_opb = writeback_data;
            2'd2:    w_opb = r_em_alu;
            default: w_opb = r_de_srcb;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (r_de_aluop)
            4'd0:    w_alu = w_opa + w_opb;
            4'd1:    w_alu = w_opa - w_opb;
            4'd2:    w_alu = w_opa & w_opb;
            4'd3:    w_alu = w_opa | w_opb;
            4'd4:    w_alu = w_opa ^ w_opb;
            4'd5:    w_alu = w_opa << w_opb[3:0];
            4'd6:    w_alu = w_opa >> w_opb[3:0];
            4'd7:    w_alu = $unsigned($signed(w_opa) >>> w_opb[3:0]);
            4'd8:    w_alu = w_opa * w_opb;
            4'd9:    w_alu = w_opb;
            4'd10:   w_alu = w_opa;
            4'd11:   w_alu = ~w_opa;
            4'd12:   w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_opa) < $signed(w_opb))};
            4'd13:   w_alu = {{(DATA_W-1){1'b0}}, (w_opa < w_opb)};
            4'd14:   w_alu = ~(w_opa | w_opb);
            default: w_alu = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;
    logic            w_flag_c;
    logic            w_flag_v;
    logic [3:0]      r_em_flags;

    assign w_sum  = {1'b0, w_opa} + {1'b0, w_opb};
    assign w_diff = {1'b0, w_opa} - {1'b0, w_opb};

    // C is carry for ADD and borrow for SUB; other ops leave C and V clear.
    always_comb begin
        w_flag_c = 1'b0;
        w_flag_v = 1'b0;
        if (r_de_aluop == 4'd0) begin
            w_flag_c = w_sum[DATA_W];
            w_flag_v = (w_opa[DATA_W-1] == w_opb[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != w_opa[DATA_W-1]);
        end else if (r_de_aluop == 4'd1) begin
            w_flag_c = w_diff[DATA_W];
            w_flag_v = (w_opa[DATA_W-1] != w_opb[DATA_W-1]) &&
                       (w_diff[DATA_W-1] != w_opa[DATA_W-1]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_em_flags <= '0;
        else        r_em_flags <= {(w_alu == '0), w_alu[DATA_W-1], w_flag_c, w_flag_v};
    end

    assign flags_memory = r_em_flags;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_em_wre   <= 1'b0;
            r_em_wme   <= 1'b0;
            r_em_wbsel <= '0;
            r_em_alu   <= '0;
            r_em_srca  <= '0;
            r_em_srcb  <= '0;
            r_em_rd    <= '0;
        end else begin
            r_em_wre   <= r_de_wre;
            r_em_wme   <= r_de_wme;
            r_em_wbsel <= r_de_wbsel;
            r_em_alu   <= w_alu;
            r_em_srca  <= w_opa;
            r_em_srcb  <= w_opb;
            r_em_rd    <= r_de_rd;
        end
    end

    assign rs1_execute                      = r_de_rs1;
    assign rs2_execute                      = r_de_rs2;
    assign rd_execute                       = r_de_rd;
    assign write_memory_enable_execute      = r_de_wme;
    assign wre_memory                       = r_em_wre;
    assign write_memory_enable_memory       = r_em_wme;
    assign select_writeback_data_mux_memory = r_em_wbsel;
    assign alu_result_memory                = r_em_alu;
    assign srcA_memory                      = r_em_srca;
    assign srcB_memory                      = r_em_srcb;
    assign rd_memory                        = r_em_rd;

endmodule

// File: tb/tb_execute_stage_slice.sv
// Bench for execute_stage_slice: directed and random instruction stream with an expected-result queue.
// Flags are checked when built with ALU_FLAGS_EN.
module tb_execute_stage_slice;

  typedef struct packed {
    logic        wre;
    logic        wme;
    logic [1:0]  wb;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
  } de_t;

  typedef struct packed {
    logic        wre;
    logic        wme;
    logic [1:0]  wb;
    logic [15:0] alu;
    logic [15:0] sa;
    logic [15:0] sb;
    logic [3:0]  rd;
    logic [3:0]  flags;
  } em_t;

  logic        clk;
  logic        reset;
  logic        flush_de;
  logic [15:0] ctrl_decode;
  logic [15:0] srcA_in;
  logic [15:0] srcB_in;
  logic [3:0]  rs1_decode;
  logic [3:0]  rs2_decode;
  logic [3:0]  rd_decode;
  logic [1:0]  select_forward_mux_A;
  logic [1:0]  select_forward_mux_B;
  logic [15:0] writeback_data;
  logic [3:0]  rs1_execute;
  logic [3:0]  rs2_execute;
  logic [3:0]  rd_execute;
  logic        write_memory_enable_execute;
  logic        wre_memory;
  logic        write_memory_enable_memory;
  logic [1:0]  select_writeback_data_mux_memory;
  logic [15:0] alu_result_memory;
  logic [15:0] srcA_memory;
  logic [15:0] srcB_memory;
  logic [3:0]  rd_memory;
`ifdef ALU_FLAGS_EN
  logic [3:0]  flags_memory;
`endif

  em_t exp_q[$];
  de_t in_exec;
  logic [15:0] em_alu;
  int total_cnt;
  int bad_cnt;

  execute_stage_slice dut (
    .clk(clk),
    .reset(reset),
    .flush_de(flush_de),
    .ctrl_decode(ctrl_decode),
    .srcA_in(srcA_in),
    .srcB_in(srcB_in),
    .rs1_decode(rs1_decode),
    .rs2_decode(rs2_decode),
    .rd_decode(rd_decode),
    .select_forward_mux_A(select_forward_mux_A),
    .select_forward_mux_B(select_forward_mux_B),
    .writeback_data(writeback_data),
    .rs1_execute(rs1_execute),
    .rs2_execute(rs2_execute),
    .rd_execute(rd_execute),
    .write_memory_enable_execute(write_memory_enable_execute),
    .wre_memory(wre_memory),
    .write_memory_enable_memory(write_memory_enable_memory),
    .select_writeback_data_mux_memory(select_writeback_data_mux_memory),
    .alu_result_memory(alu_result_memory),
    .srcA_memory(srcA_memory),
    .srcB_memory(srcB_memory),
`ifdef ALU_FLAGS_EN
    .flags_memory(flags_memory),
`endif
    .rd_memory(rd_memory)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference ALU: returns {Z,N,C,V,result}.
  function automatic logic [19:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] y;
    logic [16:0] t;
    logic c;
    logic v;
    y = 16'h0;
    c = 1'b0;
    v = 1'b0;
    t = 17'h0;
    case (op)
      4'd0:  begin t = {1'b0, a} + {1'b0, b}; y = t[15:0]; c = t[16]; v = (a[15] == b[15]) && (y[15] != a[15]); end
      4'd1:  begin t = {1'b0, a} - {1'b0, b}; y = t[15:0]; c = t[16]; v = (a[15] != b[15]) && (y[15] != a[15]); end
      4'd2:  y = a & b;
      4'd3:  y = a | b;
      4'd4:  y = a ^ b;
      4'd5:  y = a << b[3:0];
      4'd6:  y = a >> b[3:0];
      4'd7:  y = $unsigned($signed(a) >>> b[3:0]);
      4'd8:  y = a * b;
      4'd9:  y = b;
      4'd10: y = a;
      4'd11: y = ~a;
      4'd12: y = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd13: y = (a < b) ? 16'd1 : 16'd0;
      4'd14: y = ~(a | b);
      default: y = 16'h0;
    endcase
    return {(y == 16'h0), y[15], c, v, y};
  endfunction

  // One cycle: check outputs, then drive a new instruction plus the selects for the one in execute.
  task automatic step(input logic [15:0] c, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                      input logic fl, input logic [1:0] sel_a, input logic [1:0] sel_b,
                      input logic [15:0] wb);
    em_t e;
    logic [15:0] fa;
    logic [15:0] fb;
    logic [19:0] r;
    @(negedge clk);
    check_eq("rs1_execute", rs1_execute, in_exec.rs1);
    check_eq("rs2_execute", rs2_execute, in_exec.rs2);
    check_eq("rd_execute", rd_execute, in_exec.rd);
    check_eq("wme_execute", write_memory_enable_execute, in_exec.wme);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("wre_memory", wre_memory, e.wre);
      check_eq("wme_memory", write_memory_enable_memory, e.wme);
      check_eq("wbsel_memory", select_writeback_data_mux_memory, e.wb);
      check_eq("alu_result_memory", alu_result_memory, e.alu);
      check_eq("srcA_memory", srcA_memory, e.sa);
      check_eq("srcB_memory", srcB_memory, e.sb);
      check_eq("rd_memory", rd_memory, e.rd);
`ifdef ALU_FLAGS_EN
      check_eq("flags_memory", flags_memory, e.flags);
`endif
      em_alu = e.alu;
    end
    fa = (sel_a == 2'd1) ? wb : (sel_a == 2'd2) ? em_alu : in_exec.a;
    fb = (sel_b == 2'd1) ? wb : (sel_b == 2'd2) ? em_alu : in_exec.b;
    r = alu_ref(in_exec.op, fa, fb);
    e.wre = in_exec.wre;
    e.wme = in_exec.wme;
    e.wb = in_exec.wb;
    e.alu = r[15:0];
    e.sa = fa;
    e.sb = fb;
    e.rd = in_exec.rd;
    e.flags = r[19:16];
    exp_q.push_back(e);
    ctrl_decode = c;
    srcA_in = a;
    srcB_in = b;
    rs1_decode = s1;
    rs2_decode = s2;
    rd_decode = d;
    flush_de = fl;
    select_forward_mux_A = sel_a;
    select_forward_mux_B = sel_b;
    writeback_data = wb;
    if (fl) begin
      in_exec = '0;
    end else begin
      in_exec.wre = c[0];
      in_exec.wme = c[1];
      in_exec.wb = c[3:2];
      in_exec.op = c[7:4];
      in_exec.a = a;
      in_exec.b = b;
      in_exec.rs1 = s1;
      in_exec.rs2 = s2;
      in_exec.rd = d;
    end
  endtask

  task automatic zero_inputs();
    flush_de = 1'b0;
    ctrl_decode = 16'h0;
    srcA_in = 16'h0;
    srcB_in = 16'h0;
    rs1_decode = 4'h0;
    rs2_decode = 4'h0;
    rd_decode = 4'h0;
    select_forward_mux_A = 2'd0;
    select_forward_mux_B = 2'd0;
    writeback_data = 16'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_alu"}, alu_result_memory, 32'h0);
    check_eq({tag, "_srcA"}, srcA_memory, 32'h0);
    check_eq({tag, "_srcB"}, srcB_memory, 32'h0);
    check_eq({tag, "_ctl"}, {wre_memory, write_memory_enable_memory, select_writeback_data_mux_memory, rd_memory}, 32'h0);
    check_eq({tag, "_de"}, {rs1_execute, rs2_execute, rd_execute, write_memory_enable_execute}, 32'h0);
`ifdef ALU_FLAGS_EN
    check_eq({tag, "_flags"}, flags_memory, 32'h0);
`endif
  endtask

  // Release at a falling edge with zeroed inputs so the model restarts from an empty pipe.
  task automatic release_reset();
    @(negedge clk);
    zero_inputs();
    reset = 1'b1;
    exp_q.delete();
    in_exec = '0;
    em_alu = 16'h0;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt = 0;
    in_exec = '0;
    em_alu = 16'h0;
    zero_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_init");
    release_reset();

    // Directed sequence: selects given in one step apply to the instruction issued in the step before.
    step(16'h0001, 16'h0003, 16'h0004, 4'd1, 4'd2, 4'd5, 1'b0, 2'd0, 2'd0, 16'h0);
    step(16'h0001, 16'h9999, 16'h0001, 4'd5, 4'd3, 4'd6, 1'b0, 2'd0, 2'd0, 16'h0);
    step(16'h0011, 16'h0000, 16'h0001, 4'd4, 4'd5, 4'd7, 1'b0, 2'd2, 2'd0, 16'h0);
    check_eq("add_lit", alu_result_memory, 32'h0007);
    check_eq("add_rd", rd_memory, 32'd5);
    check_eq("add_wre", wre_memory, 32'd1);
    step(16'h0071, 16'h8000, 16'h0003, 4'd0, 4'd0, 4'd8, 1'b0, 2'd0, 2'd0, 16'h0);
    check_eq("fwd_mem_lit", alu_result_memory, 32'h0008);
    step(16'h0001, 16'h0005, 16'h7777, 4'd0, 4'd0, 4'd2, 1'b0, 2'd0, 2'd0, 16'h0);
    check_eq("sub_wrap_lit", alu_result_memory, 32'hFFFF);
    step(16'h0003, 16'h0001, 16'h0002, 4'd1, 4'd1, 4'd9, 1'b1, 2'd0, 2'd1, 16'h0010);
    check_eq("sra_lit", alu_result_memory, 32'hF000);
    step(16'h0002, 16'h0020, 16'h1234, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 2'd0, 16'h0);
    check_eq("fwd_wb_lit", alu_result_memory, 32'h0015);
    step(16'h0001, 16'h7FFF, 16'h0001, 4'd0, 4'd0, 4'd3, 1'b0, 2'd0, 2'd0, 16'h0);
    check_eq("flush_lit", {wre_memory, write_memory_enable_memory, alu_result_memory}, 32'h0);
    step(16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 2'd0, 16'h0);
    check_eq("store_wme", write_memory_enable_memory, 32'd1);
    check_eq("store_srcA", srcA_memory, 32'h0020);
    check_eq("store_srcB", srcB_memory, 32'h1234);
    step(16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 2'd0, 16'h0);
    check_eq("ovf_lit", alu_result_memory, 32'h8000);
`ifdef ALU_FLAGS_EN
    check_eq("ovf_flags", flags_memory, 32'h5);
`endif

    // Random stream with random flushes, forwarding selects and reserved control bits.
    for (int i = 0; i < 40; i++) begin
      step(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           16'($urandom_range(0, 65535)));
    end

    // Asynchronous reset mid-cycle with a loaded pipe.
    step(16'h0031, 16'h00F0, 16'h0F00, 4'd3, 4'd4, 4'd9, 1'b0, 2'd0, 2'd0, 16'h0);
    step(16'h0013, 16'h1111, 16'h0011, 4'd6, 4'd7, 4'd10, 1'b0, 2'd0, 2'd0, 16'h0);
    @(posedge clk);
    #1;
    check_eq("preload_nonzero", (alu_result_memory != 16'h0) && (rd_execute != 4'h0), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("reset_async");
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    release_reset();

    for (int i = 0; i < 30; i++) begin
      step(16'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           16'($urandom_range(0, 65535)));
    end
    step(16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 2'd0, 16'h0);
    step(16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 2'd0, 16'h0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/execute_stage_slice.md
Name: execute_stage_slice

Overview:
- Execute-stage slice of the 16-bit 5-stage CPU pipeline: the Decode/Execute register, the operand forwarding muxes, the ALU and the Execute/Memory register.
- Sits between the decode logic (control unit, NOP mux, register file) and the RAM/MemoryWriteback stage.
- The hazard and forwarding units are external and drive the flush and forward selects.

Parameters:
- DATA_W, 16, datapath width.
- REG_AW, 4, register-address width.
- CTRL_W, 16, control-word width from the NOP mux.

Ports:
- clk  in  1  single rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush_de  in  1  load a bubble into the D/E register this edge.
- ctrl_decode  in  CTRL_W  control word (NOP-mux output).
- srcA_in, srcB_in  in  DATA_W  register-file read data rd1/rd2.
- rs1_decode, rs2_decode, rd_decode  in  REG_AW  instruction fields [3:0], [7:4], [11:8].
- select_forward_mux_A, select_forward_mux_B  in  2  forwarding selects.
- writeback_data  in  DATA_W  forwarded writeback value.
- rs1_execute, rs2_execute, rd_execute  out  REG_AW  D/E fields, for the hazard and forwarding units.
- write_memory_enable_execute  out  1  D/E memory-write bit, for hazard detection.
- wre_memory  out  1  E/M register-write enable.
- write_memory_enable_memory  out  1  E/M RAM write enable.
- select_writeback_data_mux_memory  out  2  E/M writeback select.
- alu_result_memory  out  DATA_W  E/M ALU result; also the internal forward source.
- srcA_memory, srcB_memory  out  DATA_W  E/M forwarded operands (RAM address and data).
- rd_memory  out  REG_AW  E/M destination register.

Behaviour:
- Control word fields:
  - bit0 = wre
  - bit1 = write_memory_enable
  - bits[3:2] = writeback select
  - bits[7:4] = aluOp
  - bits[15:8] reserved, ignored.
- D/E register:
  - Captures ctrl fields, srcA, srcB, rs1, rs2 and rd on each rising clk.
  - If flush_de=1, it captures all zeros instead. Zero is the NOP: no writes, aluOp ADD.
- Forward muxes (combinational), per operand:
  - select 0 = D/E value.
  - select 1 = writeback_data.
  - select 2 = alu_result_memory.
  - select 3 = D/E value.
- ALU (combinational, A/B are the forwarded operands), result is DATA_W bits:
  - 0 ADD.
  - 1 SUB (A-B).
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL, shift A by B[3:0].
  - 6 SRL, shift A by B[3:0].
  - 7 SRA, shift A by B[3:0].
  - 8 MUL, low 16 bits.
  - 9 PASS B.
  - 10 PASS A.
  - 11 NOT A.
  - 12 SLT signed, result 1 or 0.
  - 13 SLTU, result 1 or 0.
  - 14 NOR.
  - 15 result 0.
- ALU arithmetic rules: add, sub and mul wrap modulo 2^16 and discard carry.
- E/M register:
  - On each rising clk it captures wre, write_memory_enable, writeback select, the ALU result, forwarded A, forwarded B and rd, all from the D/E stage.
  - It has no enable and no flush.
- Latency: inputs captured at edge N reach the E/M outputs at edge N+1.
- Reset:
  - reset low asynchronously clears every register in both stages to 0, immediately and independent of clk.
  - Release is sampled at the next rising edge.
  - Reset asserted mid-operation discards all in-flight instructions.
- Simultaneous events:
  - Forwarding from alu_result_memory while the E/M register updates uses the pre-edge value.
  - flush_de only affects the D/E register; the instruction already in execute proceeds to E/M.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined:
  - The ALU produces flags Z (result==0), N (result[15]), C (carry/borrow of ADD/SUB, else 0) and V (signed overflow of ADD/SUB, else 0).
  - The E/M register captures them on output port flags_memory [3:0] = {Z,N,C,V}, reset 0.
- When undefined: the port and flag logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: drive reset=0 mid-cycle with nonzero data loaded -> all outputs 0 immediately, with no clock edge.
- ADD: ctrl=0x0001, srcA=0x0003, srcB=0x0004, rd=5, both selects 0 -> two edges later alu_result_memory=0x0007, rd_memory=5, wre_memory=1.
- SUB wrap and SRA:
  - SUB of 0x0000-0x0001 -> 0xFFFF.
  - SRA (aluOp 7) with A=0x8000, B=0x0003 -> 0xF000.
- Forwarding:
  - select_A=2 with previous result 0x0007 in E/M, srcB=0x0001, ADD -> 0x0008.
  - select_B=1 with writeback_data=0x0010 -> that value is used as B.
- Flush: flush_de=1 with ctrl=0x0003 -> next E/M has wre_memory=0, write_memory_enable_memory=0, alu_result_memory=0.
- Store path: ctrl=0x0002, srcA=0x0020, srcB=0x1234 -> write_memory_enable_memory=1, srcA_memory=0x0020, srcB_memory=0x1234.
- With ALU_FLAGS_EN defined: 0x7FFF+0x0001 -> flags_memory=4'b0101 (N=1, V=1).
